// File: rtl/bkp_write_master.sv
// BKP register-write bus initiator: FWFT request queue feeding a SETUP/HIGH/LOW strobe sequencer.
// Optional status synchroniser enabled by defining BKP_TX_STATUS_EN.
module bkp_write_master #(
  parameter int FIFO_DEPTH = 4,
  parameter int SETUP_CYC  = 1,
  parameter int HIGH_CYC   = 4,
  parameter int LOW_CYC    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_index_i,
  input  logic [31:0] req_data_i,
  output logic        bkt_ready_o,
  output logic [31:0] bkt_index_o,
  output logic [31:0] bkt_data_o,
  output logic        busy_o,
  output logic        wr_done_o,
  input  logic [31:0] bk_status_i,
  output logic [31:0] status_o,
  output logic        status_chg_o
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int MAXC = (SETUP_CYC > HIGH_CYC) ? ((SETUP_CYC > LOW_CYC) ? SETUP_CYC : LOW_CYC)
                                               : ((HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC);
  localparam int CW   = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] HIGH_LD  = CW'(HIGH_CYC - 1);
  localparam logic [CW-1:0] LOW_LD   = CW'(LOW_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);

  typedef struct packed {
    logic [31:0] index;
    logic [31:0] data;
  } req_t;

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

  req_t          mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          empty, full, push, pop;
  state_t        state, next_state;
  logic [CW-1:0] cnt, next_cnt;
  req_t          head;

  // Extra wrap bit distinguishes full from empty when the address bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = (state == IDLE) && !empty;
  // A pop in the same cycle frees a slot, so a full queue can still take a push.
  assign req_ready_o = !full || pop;
  assign push  = req_valid_i && req_ready_o;
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= '{index: req_index_i, data: req_data_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      bkt_ready_o <= 1'b0;
      bkt_index_o <= '0;
      bkt_data_o  <= '0;
    end else begin
      state       <= next_state;
      cnt         <= next_cnt;
      bkt_ready_o <= (next_state == HIGH);
      if (pop) begin
        bkt_index_o <= head.index;
        bkt_data_o  <= head.data;
      end
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt - CNT_ONE;
    unique case (state)
      IDLE: begin
        next_cnt = cnt;
        if (!empty) begin
          next_state = SETUP;
          next_cnt   = SETUP_LD;
        end
      end
      SETUP: if (cnt == '0) begin
        next_state = HIGH;
        next_cnt   = HIGH_LD;
      end
      HIGH: if (cnt == '0) begin
        next_state = LOW;
        next_cnt   = LOW_LD;
      end
      LOW: if (cnt == '0) begin
        next_state = IDLE;
        next_cnt   = '0;
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  assign wr_done_o = (state == LOW) && (cnt == '0);
  assign busy_o    = !empty || (state != IDLE);

`ifdef BKP_TX_STATUS_EN
  logic [31:0] status_s1, status_s2, status_s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_s1 <= '0;
      status_s2 <= '0;
      status_s3 <= '0;
    end else begin
      status_s1 <= bk_status_i;
      status_s2 <= status_s1;
      status_s3 <= status_s2;
    end
  end

  assign status_o     = status_s2;
  assign status_chg_o = (status_s2 != status_s3);
`else
  logic status_unused;
  assign status_unused = ^bk_status_i;
  assign status_o      = '0;
  assign status_chg_o  = 1'b0;
`endif
endmodule

// File: tb/tb_bkp_write_master.sv
// Directed bench for bkp_write_master: bus monitor + model slave, table-driven burst and hand sequences.
module tb_bkp_write_master;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_index_i = '0;
  logic [31:0] req_data_i = '0;
  logic        bkt_ready_o;
  logic [31:0] bkt_index_o, bkt_data_o;
  logic        busy_o, wr_done_o;
  logic [31:0] bk_status_i = '0;
  logic [31:0] status_o;
  logic        status_chg_o;

  bkp_write_master dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_index_i(req_index_i), .req_data_i(req_data_i),
    .bkt_ready_o(bkt_ready_o), .bkt_index_o(bkt_index_o), .bkt_data_o(bkt_data_o),
    .busy_o(busy_o), .wr_done_o(wr_done_o),
    .bk_status_i(bk_status_i), .status_o(status_o), .status_chg_o(status_chg_o)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total    = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor and model slave: commit on each rising strobe, watch bus stability.
  logic [31:0] rise_idx[$], rise_dat[$];
  int          rise_cyc[$];
  logic [31:0] slave_mem [logic [31:0]];
  logic [31:0] cur_i = '0, cur_d = '0;
  logic        prev_rdy = 1'b0, prev_busy = 1'b0, prev_done = 1'b0;
  int stab_err = 0, done_cnt = 0, done_cyc = 0, fall_cyc = 0, busy_fall_cyc = 0;
  int done_err = 0, chg_cnt = 0;

  always @(negedge clk) begin
    if (bkt_ready_o && !prev_rdy) begin
      rise_idx.push_back(bkt_index_o);
      rise_dat.push_back(bkt_data_o);
      rise_cyc.push_back(cyc);
      cur_i = bkt_index_o;
      cur_d = bkt_data_o;
      slave_mem[bkt_index_o] = bkt_data_o;
    end
    if (!bkt_ready_o && prev_rdy) fall_cyc = cyc;
    if (bkt_ready_o && (bkt_index_o !== cur_i || bkt_data_o !== cur_d)) stab_err++;
    if (wr_done_o) begin
      done_cnt++;
      done_cyc = cyc;
      if (bkt_index_o !== cur_i || bkt_data_o !== cur_d) stab_err++;
      if (prev_done) done_err++;
    end
    if (!busy_o && prev_busy) busy_fall_cyc = cyc;
    if (status_chg_o) chg_cnt++;
    prev_rdy  = bkt_ready_o;
    prev_busy = busy_o;
    prev_done = wr_done_o;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  int acc_q[$];
  int first_stall;

  // Called at a negedge; holds the request until accepted (bounded), logs accept cycle.
  task automatic push(input logic [31:0] i, input logic [31:0] d);
    int w = 0;
    req_valid_i = 1'b1;
    req_index_i = i;
    req_data_i  = d;
    #1;
    while (!req_ready_o && w < 200) begin
      @(negedge clk); #1; w++;
    end
    if (w > 0 && first_stall < 0) first_stall = acc_q.size();
    if (!req_ready_o) check("push_timeout", 32'd0, 32'd1);
    acc_q.push_back(cyc);
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int w = 0;
    #1;
    while (busy_o && w < 1000) begin
      @(negedge clk); #1; w++;
    end
    if (busy_o) check("idle_timeout", 32'd0, 32'd1);
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] idx;
    logic [31:0] dat;
    int          exp_rise;   // rise cycle relative to first accept
  } vec_t;
  vec_t tab[6];

  initial begin
    int s, a0, w;

    tab[0] = '{32'h0000_0191, 32'h0000_00A1, 3};
    tab[1] = '{32'h0000_0000, 32'h0000_0001, 13};
    tab[2] = '{32'h0000_0192, 32'hDEAD_BEEF, 23};
    tab[3] = '{32'hFFFF_FFFF, 32'h1234_5678, 33};
    tab[4] = '{32'h0000_0193, 32'h0000_0000, 43};
    tab[5] = '{32'h0000_0194, 32'hA5A5_A5A5, 53};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_bkt_ready", bkt_ready_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_wr_done", wr_done_o, 0);
    check("rst_bkt_index", bkt_index_o, 0);
    check("rst_bkt_data", bkt_data_o, 0);
    check("rst_status", status_o, 0);
    check("rst_status_chg", status_chg_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("rst_req_ready", req_ready_o, 1);
    @(negedge clk);

    // 1: single write
    first_stall = -1;
    acc_q.delete();
    push(32'h191, 32'hA);
    wait_idle();
    check("t1_rise_count", rise_cyc.size(), 1);
    check("t1_latency", rise_cyc[0] - acc_q[0], 3);
    check("t1_high_len", fall_cyc - rise_cyc[0], 4);
    check("t1_low_len", done_cyc - fall_cyc, 3);
    check("t1_done_count", done_cnt, 1);
    check("t1_index", rise_idx[0], 32'h191);
    check("t1_data", rise_dat[0], 32'hA);
    check("t1_slave_reg", slave_mem[32'h191], 32'hA);
    check("t1_idle_hold_idx", bkt_index_o, 32'h191);
    check("t1_idle_hold_dat", bkt_data_o, 32'hA);

    // 2: burst of 6 back-to-back (one goes straight to the bus, 4 queue, 6th stalls)
    s = rise_cyc.size();
    first_stall = -1;
    acc_q.delete();
    for (int k = 0; k < 6; k++) push(tab[k].idx, tab[k].dat);
    wait_idle();
    a0 = acc_q[0];
    check("t2_first_stall", first_stall, 5);
    check("t2_rise_count", rise_cyc.size() - s, 6);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("t2_idx_%0d", k), rise_idx[s+k], tab[k].idx);
      check($sformatf("t2_dat_%0d", k), rise_dat[s+k], tab[k].dat);
      check($sformatf("t2_rise_%0d", k), rise_cyc[s+k] - a0, tab[k].exp_rise);
    end
    check("t2_done_count", done_cnt, 7);
    check("t2_busy_fall", busy_fall_cyc - done_cyc, 1);
    check("t2_slave_idx0", slave_mem[32'h0], 32'h1);

    // 3: full queue, push lands in the pop cycle; 14 writes wrap pointers 3+ times
    s = rise_cyc.size();
    first_stall = -1;
    acc_q.delete();
    for (int k = 0; k < 14; k++) push(32'h300 + k, 32'h11 * k);
    wait_idle();
    check("t3_first_stall", first_stall, 5);
    check("t3_push_on_full", acc_q[5] - acc_q[0], 11);
    for (int k = 6; k < 14; k++)
      check($sformatf("t3_acc_gap_%0d", k), acc_q[k] - acc_q[k-1], 10);
    check("t3_rise_count", rise_cyc.size() - s, 14);
    for (int k = 0; k < 14; k++) begin
      check($sformatf("t3_idx_%0d", k), rise_idx[s+k], 32'h300 + k);
      check($sformatf("t3_dat_%0d", k), rise_dat[s+k], 32'h11 * k);
    end

    // 4: reset during HIGH
    s = rise_cyc.size();
    for (int k = 0; k < 3; k++) push(32'h400 + k, 32'hB0 + k);
    w = 0;
    while (!bkt_ready_o && w < 50) begin
      @(negedge clk); w++;
    end
    check("t4_reached_high", bkt_ready_o, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t4_strobe_drop", bkt_ready_o, 0);
    check("t4_busy_rst", busy_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    check("t4_queue_flushed", rise_cyc.size() - s, 1);
    check("t4_busy_after", busy_o, 0);
    @(negedge clk);
    push(32'h0, 32'h55);
    wait_idle();
    check("t4_new_write", rise_cyc.size() - s, 2);
    check("t4_new_idx", rise_idx[s+1], 32'h0);
    check("t4_slave_reg", slave_mem[32'h0], 32'h55);

    // 5: status synchroniser
    w = chg_cnt;
    bk_status_i = 32'h5;
    @(negedge clk);
`ifdef BKP_TX_STATUS_EN
    check("t5_status_1cyc", status_o, 0);
    @(negedge clk);
    check("t5_status_2cyc", status_o, 32'h5);
    repeat (10) @(negedge clk);
    check("t5_status_hold", status_o, 32'h5);
    check("t5_chg_pulses", chg_cnt - w, 1);
`else
    repeat (10) @(negedge clk);
    check("t5_status_off", status_o, 0);
    check("t5_chg_off", chg_cnt - w, 0);
`endif

    check("stability", stab_err, 0);
    check("done_pulse_width", done_err, 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
